mem_wb_stage: RTL

- Memory stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline.
- Consumes the M_* outputs of the EX/MEM register and performs the data-memory access: sw/sh/sb stores and lw/lh/lhu/lb/lbu loads, decoded from the M_IF opcode.
- Latches the results into W-stage registers that feed writeback and forwarding.

---
 rtl/cpu_defs.sv | 32 +++
 rtl/dm_load_ext.sv | 29 ++
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared pipeline definitions: opcode constants, A3sel/WDsel encodings and
// small decode helpers used by the memory stage.
package cpu_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
  localparam logic [OP_W-1:0] OP_LHU = 6'b100101;
  localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
  localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
  localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
  localparam logic [OP_W-1:0] OP_SH  = 6'b101001;
  localparam logic [OP_W-1:0] OP_SB  = 6'b101000;

  // Destination register select
  localparam logic [SEL_W-1:0] A3_RT = 2'd0;
  localparam logic [SEL_W-1:0] A3_RD = 2'd1;
  localparam logic [SEL_W-1:0] A3_RA = 2'd2;

  // Writeback data select
  localparam logic [SEL_W-1:0] WD_ALU  = 2'd0;
  localparam logic [SEL_W-1:0] WD_DM   = 2'd1;
  localparam logic [SEL_W-1:0] WD_PC8  = 2'd2;

  function automatic logic [OP_W-1:0] opcode_of(input logic [XLEN-1:0] ir);
    return ir[31:26];
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load-data extraction: selects the byte/halfword lane from the raw word and
// sign- or zero-extends it according to the load opcode.
import cpu_defs::*;

module dm_load_ext (
  input  logic [XLEN-1:0] raw_word,
  input  logic [1:0]      offset,
  input  logic [OP_W-1:0] opcode,
  output logic [XLEN-1:0] ext_c
);

  logic [15:0] half_c;
  logic [7:0]  byte_c;

  always_comb begin
    half_c = offset[1] ? raw_word[31:16] : raw_word[15:0];
    byte_c = raw_word[{offset, 3'b000} +: 8];
    ext_c  = raw_word;
    case (opcode)
      OP_LW:   ext_c = raw_word;
      OP_LH:   ext_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  ext_c = {16'h0000, half_c};
      OP_LB:   ext_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  ext_c = {24'h000000, byte_c};
      default: ext_c = raw_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory stage with data memory and the MEM/WB pipeline register.
// Optional macro DM_TRACE_EN prints every committed store in simulation.
import cpu_defs::*;

module mem_wb_stage #(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned DM_AW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [XLEN-1:0]   M_IF,
  input  logic [XLEN-1:0]   M_PCadd4,
  input  logic [XLEN-1:0]   M_BUSB,
  input  logic [XLEN-1:0]   M_ALUout,
  input  logic              M_DMEn,
  input  logic [SEL_W-1:0]  M_A3sel,
  input  logic [SEL_W-1:0]  M_WDsel,
  input  logic              M_GRFEn,
  output logic [XLEN-1:0]   W_IF,
  output logic [XLEN-1:0]   W_PCadd4,
  output logic [XLEN-1:0]   W_ALUout,
  output logic [XLEN-1:0]   W_DMout,
  output logic [SEL_W-1:0]  W_A3sel,
  output logic [SEL_W-1:0]  W_WDsel,
  output logic              W_GRFEn
);

  logic [XLEN-1:0]  mem_q [DM_WORDS];

  logic [OP_W-1:0]  op_c;
  logic             in_range_c;
  logic [DM_AW-1:0] idx_c;
  logic [XLEN-1:0]  raw_word_c;
  logic [XLEN-1:0]  wr_word_c;
  logic             wr_en_c;
  logic [XLEN-1:0]  ld_ext_c;

  logic [XLEN-1:0]  w_if_d,     w_if_q;
  logic [XLEN-1:0]  w_pcadd4_d, w_pcadd4_q;
  logic [XLEN-1:0]  w_aluout_d, w_aluout_q;
  logic [XLEN-1:0]  w_dmout_d,  w_dmout_q;
  logic [SEL_W-1:0] w_a3sel_d,  w_a3sel_q;
  logic [SEL_W-1:0] w_wdsel_d,  w_wdsel_q;
  logic             w_grfen_d,  w_grfen_q;

  // Address decode and raw read; out-of-range reads return zero
  always_comb begin
    op_c       = opcode_of(M_IF);
    in_range_c = (M_ALUout[XLEN-1:DM_AW+2] == '0);
    idx_c      = M_ALUout[DM_AW+1:2];
    raw_word_c = in_range_c ? mem_q[idx_c] : '0;
    wr_en_c    = M_DMEn & ~stall & ~reset & in_range_c;
  end

  // Byte-lane merge; any non-sh/sb store writes the whole word
  always_comb begin
    wr_word_c = raw_word_c;
    case (op_c)
      OP_SH: begin
        if (M_ALUout[1]) wr_word_c[31:16] = M_BUSB[15:0];
        else             wr_word_c[15:0]  = M_BUSB[15:0];
      end
      OP_SB:   wr_word_c[{M_ALUout[1:0], 3'b000} +: 8] = M_BUSB[7:0];
      default: wr_word_c = M_BUSB;
    endcase
  end

  dm_load_ext u_load_ext (
    .raw_word (raw_word_c),
    .offset   (M_ALUout[1:0]),
    .opcode   (op_c),
    .ext_c    (ld_ext_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) begin
        mem_q[DM_AW'(i)] <= '0;
      end
    end else if (wr_en_c) begin
      mem_q[idx_c] <= wr_word_c;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      $display("@%08h: *%08h <= %08h", M_PCadd4 - 32'd4,
               {M_ALUout[XLEN-1:2], 2'b00}, wr_word_c);
    end
  end
`endif

  // Pipeline register next-state: hold everything while stalled
  always_comb begin
    w_if_d     = w_if_q;
    w_pcadd4_d = w_pcadd4_q;
    w_aluout_d = w_aluout_q;
    w_dmout_d  = w_dmout_q;
    w_a3sel_d  = w_a3sel_q;
    w_wdsel_d  = w_wdsel_q;
    w_grfen_d  = w_grfen_q;
    if (!stall) begin
      w_if_d     = M_IF;
      w_pcadd4_d = M_PCadd4;
      w_aluout_d = M_ALUout;
      w_dmout_d  = ld_ext_c;
      w_a3sel_d  = M_A3sel;
      w_wdsel_d  = M_WDsel;
      w_grfen_d  = M_GRFEn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_if_q     <= '0;
      w_pcadd4_q <= '0;
      w_aluout_q <= '0;
      w_dmout_q  <= '0;
      w_a3sel_q  <= '0;
      w_wdsel_q  <= '0;
      w_grfen_q  <= 1'b0;
    end else begin
      w_if_q     <= w_if_d;
      w_pcadd4_q <= w_pcadd4_d;
      w_aluout_q <= w_aluout_d;
      w_dmout_q  <= w_dmout_d;
      w_a3sel_q  <= w_a3sel_d;
      w_wdsel_q  <= w_wdsel_d;
      w_grfen_q  <= w_grfen_d;
    end
  end

  assign W_IF     = w_if_q;
  assign W_PCadd4 = w_pcadd4_q;
  assign W_ALUout = w_aluout_q;
  assign W_DMout  = w_dmout_q;
  assign W_A3sel  = w_a3sel_q;
  assign W_WDsel  = w_wdsel_q;
  assign W_GRFEn  = w_grfen_q;

endmodule
